// File: rtl/polar_encoder.sv
// polar_encoder
//   Serial-in iterative polar encoder. Information bits arrive one per
//   handshake and are placed at the non-frozen indices of u (frozen indices
//   are forced to 0). The working register is then transformed in place with
//   one butterfly stage per clock, giving x = u * F^{(x)n}. The result is
//   shown as raw bits and as a sign-magnitude LLR vector. The LLR vector
//   uses the same layout as the SC decoder's channel input.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_bit     information bit
//   in_valid   in_bit is valid
//   in_ready   encoder takes in_bit this cycle (FILL on a non-frozen index)
//   out_valid  codeword / llr_out valid (OUT state)
//   out_ready  consumer accepts the output
//   codeword   x, bit i = x_i (shows the working register outside OUT)
//   llr_out    N fields of Q bits, field i = {x_i, LLR_MAG}
//   busy       high while encoding or presenting a result
module polar_encoder #(
  parameter int                n           = 5,
  parameter int                Q           = 6,
  parameter logic [2**n-1:0]   frozen_mask = '0,
  parameter int                LLR_MAG     = 2**(Q-1)-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2**n-1:0]  codeword,
  output logic [2**n*Q-1:0] llr_out,
  output logic             busy
);

  localparam int N  = 2**n;
  localparam int SW = (n > 1) ? $clog2(n) : 1;
  // Magnitude is truncated to the Q-1 magnitude bits of each field.
  localparam logic [Q-2:0] MAG = (Q-1)'(LLR_MAG);

  typedef enum logic [1:0] {FILL, ENC, OUT} state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    idx_q, idx_d;
  logic [SW-1:0]   stg_q, stg_d;
  logic [N-1:0]    x_q, x_d;
  logic [N-1:0]    enc_x;

  // Butterfly network: for stage s, every index j with bit s clear takes
  // x[j] ^ x[j + 2**s]; indices with bit s set keep their value. Each bit
  // selects its candidate for the current stage.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic [n-1:0] cand;
    for (genvar gs = 0; gs < n; gs++) begin : g_stage
      if (((gi >> gs) & 1) == 0) begin : g_upper
        assign cand[gs] = x_q[gi] ^ x_q[gi + (1 << gs)];
      end else begin : g_lower
        assign cand[gs] = x_q[gi];
      end
    end
    assign enc_x[gi] = cand[stg_q];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      stg_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stg_q   <= stg_d;
      x_q     <= x_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    logic advance;
    state_d = state_q;
    idx_d   = idx_q;
    stg_d   = stg_q;
    x_d     = x_q;
    advance = 1'b0;
    case (state_q)
      FILL: begin
        if (frozen_mask[idx_q]) begin
          x_d[idx_q] = 1'b0;
          advance    = 1'b1;
        end else if (in_valid) begin
          x_d[idx_q] = in_bit;
          advance    = 1'b1;
        end
        if (advance) begin
          idx_d = idx_q + 1'b1;     // wraps to 0 after N-1
          if (idx_q == n'(N-1)) begin
            stg_d   = '0;
            state_d = ENC;
          end
        end
      end
      ENC: begin
        x_d   = enc_x;
        stg_d = stg_q + 1'b1;
        if (stg_q == SW'(n-1)) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          idx_d   = '0;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == FILL) && !frozen_mask[idx_q];
    out_valid = (state_q == OUT);
    busy      = (state_q == ENC) || (state_q == OUT);
  end

  assign codeword = x_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_llr
    assign llr_out[gi*Q +: Q] = {x_q[gi], MAG};
  end

endmodule

// File: tb/tb_polar_encoder.sv
module tb_polar_encoder;

  localparam int NN = 3;
  localparam int N  = 8;
  localparam int Q  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v, in_bit_v, in_valid_v, out_ready_v;
  logic [2:0] in_ready_v, out_valid_v, busy_v;
  logic [7:0]  cw_v  [3];
  logic [47:0] llr_v [3];

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0: frozen 0x17 (info indices 3,5,6,7); 1: all frozen; 2: none.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam logic [7:0] M = (gi == 0) ? 8'h17 : ((gi == 1) ? 8'hFF : 8'h00);
    polar_encoder #(.n(NN), .Q(Q), .frozen_mask(M)) u_dut (
      .clk       (clk),
      .rst       (rst_v[gi]),
      .in_bit    (in_bit_v[gi]),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready_v[gi]),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready_v[gi]),
      .codeword  (cw_v[gi]),
      .llr_out   (llr_v[gi]),
      .busy      (busy_v[gi])
    );
  end

  function automatic logic [7:0] mask_of(input int d);
    return (d == 0) ? 8'h17 : ((d == 1) ? 8'hFF : 8'h00);
  endfunction

  function automatic int info_count(input logic [7:0] mask);
    int k = 0;
    for (int i = 0; i < N; i++) if (!mask[i]) k++;
    return k;
  endfunction

  // Reference: scatter info bits over non-frozen indices, then
  // x_j = XOR of u_k over every k whose bit set contains j's bit set.
  function automatic logic [7:0] ref_cw(input logic [7:0] mask, input logic [7:0] info);
    logic [7:0] u = '0;
    logic [7:0] x = '0;
    int slot = 0;
    for (int i = 0; i < N; i++) begin
      if (!mask[i]) begin
        u[i] = info[slot];
        slot++;
      end
    end
    for (int j = 0; j < N; j++)
      for (int k = 0; k < N; k++)
        if ((k & j) == j) x[j] = x[j] ^ u[k];
    return x;
  endfunction

  function automatic logic [47:0] ref_llr(input logic [7:0] x);
    logic [47:0] l = '0;
    for (int i = 0; i < N; i++) l[i*Q +: Q] = {x[i], 5'h1F};
    return l;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input int d);
    logic [7:0] m = mask_of(d);
    check_eq("rst_out_valid", out_valid_v[d], 1'b0);
    check_eq("rst_busy", busy_v[d], 1'b0);
    check_eq("rst_codeword", cw_v[d], 8'h00);
    check_eq("rst_llr", llr_v[d], ref_llr(8'h00));
    check_eq("rst_in_ready", in_ready_v[d], !m[0]);
  endtask

  // Drives one frame into DUT d starting at its cycle 0 (called on a
  // negedge). Optional stall of stall_len cycles before info slot
  // stall_slot, hold cycles of out_ready=0, and reset at cycle abort_at.
  task automatic run_frame(input int d, input logic [7:0] info, input int stall_slot,
                           input int stall_len, input int hold, input int abort_at);
    logic [7:0]  m = mask_of(d);
    int          k = info_count(m);
    int          c = 0;
    int          pos = 0;
    int          slot = 0;
    int          stalled = 0;
    int          exp_c;
    logic [7:0]  exp_x;
    exp_c = N + NN + ((stall_slot < k) ? stall_len : 0);
    exp_x = ref_cw(m, info);
    while (!out_valid_v[d] && c < 60) begin
      if (c == abort_at) begin
        rst_v[d] = 1'b1;
        in_valid_v[d] = 1'b0;
        @(negedge clk);
        check_reset(d);
        rst_v[d] = 1'b0;
        $display("dut%0d frame info=%0h aborted at cycle %0d", d, info, c);
        return;
      end
      if (pos < N) begin
        check_eq("in_ready_fill", in_ready_v[d], !m[pos]);
        if (m[pos]) begin
          in_valid_v[d] = 1'b0;
          pos++;
        end else if (slot == stall_slot && stalled < stall_len) begin
          in_valid_v[d] = 1'b0;
          stalled++;
        end else begin
          in_valid_v[d] = 1'b1;
          in_bit_v[d]   = info[slot];
          slot++;
          pos++;
        end
      end else begin
        in_valid_v[d] = 1'b0;
        check_eq("in_ready_enc", in_ready_v[d], 1'b0);
        check_eq("busy_enc", busy_v[d], 1'b1);
      end
      @(negedge clk);
      c++;
    end
    in_valid_v[d] = 1'b0;
    check_eq("out_valid_cycle", c, exp_c);
    check_eq("codeword", cw_v[d], exp_x);
    check_eq("llr_out", llr_v[d], ref_llr(exp_x));
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_out_valid", out_valid_v[d], 1'b1);
      check_eq("hold_in_ready", in_ready_v[d], 1'b0);
      check_eq("hold_codeword", cw_v[d], exp_x);
      check_eq("hold_llr", llr_v[d], ref_llr(exp_x));
      @(negedge clk);
    end
    check_eq("out_valid_pre_hs", out_valid_v[d], 1'b1);
    check_eq("in_ready_out", in_ready_v[d], 1'b0);
    out_ready_v[d] = 1'b1;
    @(negedge clk);
    out_ready_v[d] = 1'b0;
    check_eq("out_valid_post_hs", out_valid_v[d], 1'b0);
    check_eq("busy_post_hs", busy_v[d], 1'b0);
    $display("dut%0d frame info=%0h stall=%0d@%0d hold=%0d -> cw=%0h at cycle %0d (exp %0h at %0d)",
             d, info, stall_len, stall_slot, hold, exp_x, c, exp_x, exp_c);
  endtask

  initial begin
    rst_v       = 3'b111;
    in_bit_v    = '0;
    in_valid_v  = '0;
    out_ready_v = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset(d);
    rst_v[0] = 1'b0;

    // Directed frames on frozen mask 0x17
    run_frame(0, 8'h01, 99, 0, 0, -1);   // -> 0x0F
    run_frame(0, 8'h08, 99, 0, 0, -1);   // -> 0xFF
    run_frame(0, 8'h0F, 99, 0, 0, -1);   // -> 0x96
    run_frame(0, 8'h05, 1, 3, 0, -1);    // stall at idx 5 -> cycle 14
    run_frame(0, 8'h0A, 99, 0, 5, -1);   // output held 5 cycles
    run_frame(0, 8'h03, 99, 0, 0, -1);
    run_frame(0, 8'h06, 99, 0, 0, 9);    // reset mid-ENC
    run_frame(0, 8'h01, 99, 0, 0, -1);

    // Randomized frames
    repeat (20) begin
      run_frame(0, 8'($urandom_range(0, 15)), $urandom_range(0, 5),
                $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // All-frozen and all-info masks
    rst_v[1] = 1'b0;
    run_frame(1, 8'h00, 99, 0, 0, -1);
    run_frame(1, 8'h00, 0, 2, 1, -1);
    rst_v[2] = 1'b0;
    run_frame(2, 8'h01, 99, 0, 0, -1);
    repeat (6) begin
      run_frame(2, 8'($urandom_range(0, 255)), $urandom_range(0, 9),
                $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
